alu_sched: RTL and testbench
============================

// Module: alu_sched
// PURPOSE
//   Shares the single 8-bit ALU among NREQ requesters (fetch/PC unit, execute stage, debug port).
//   Round-robin arbitration with a valid/ready request and a valid/ready response per requester.
//   Owns the ALU's in0/in1/op inputs; registers the result and zf and returns them to the winner.
//   Sits between the core control logic and the alu instance.
// PARAMETERS
//   NREQ   4   number of requesters, legal 2..4
//   W      8   operand/result width (must match the ALU)
// PORTS
//   clk        in   1        system clock, all logic on rising edge
//   rst        in   1        synchronous reset, active-high
//   req_valid  in   NREQ     requester i has an operation pending
//   req_ready  out  NREQ     one-hot; request i accepted on req_valid[i] & req_ready[i]
//   req_op     in   4*NREQ   ALU opcode of requester i, bits [4i+3:4i] (def.h encoding)
//   req_in0    in   W*NREQ   operand in0 of requester i, bits [Wi+W-1:Wi]
//   req_in1    in   W*NREQ   operand in1 of requester i
//   rsp_valid  out  NREQ     one-hot; result for requester i available
//   rsp_ready  in   NREQ     requester i consumes result on rsp_valid[i] & rsp_ready[i]
//   rsp_out    out  W        registered ALU result, shared by all requesters
//   rsp_zf     out  1        registered ALU zf (1 when result nonzero, as the ALU defines it)
//   alu_op     out  4        to ALU op
//   alu_in0    out  W        to ALU in0
//   alu_in1    out  W        to ALU in1
//   alu_out    in   W        from ALU out (combinational)
//   alu_zf     in   1        from ALU zf
// BEHAVIOUR
//   - FSM states IDLE, EXEC, RESP. Reset: state=IDLE, req_ready=0, rsp_valid=0, rsp_out=0,
//     rsp_zf=0, alu_op/alu_in0/alu_in1=0, last_grant=NREQ-1 (requester 0 wins first).
//   - IDLE: req_ready is combinational: one-hot on the winner = first i with req_valid[i],
//     searching last_grant+1, +2, ... modulo NREQ. No valid -> req_ready=0, stay IDLE.
//     On accept: latch op/in0/in1 into the alu_* registers; latch id=winner; last_grant=winner;
//     go to EXEC.
//   - EXEC: alu_* stable from the latched registers. At the end of the cycle capture
//     alu_out->rsp_out and alu_zf->rsp_zf. Go to RESP. req_ready=0.
//   - RESP: rsp_valid[id]=1, all other bits 0. Hold rsp_out/rsp_zf stable until rsp_ready[id].
//     On handshake: rsp_valid drops next cycle, state->IDLE. rsp_ready of other ids is ignored.
//   - Latency: accept in cycle T -> rsp_valid high in cycle T+2. Minimum issue interval is
//     3 cycles (accept, exec, resp with rsp_ready already high). One operation in flight at most.
//   - Fairness: a continuously valid requester waits at most NREQ-1 other operations.
//   - A requester may drop req_valid before acceptance; no grant is recorded.
//   - Wrap-around: last_grant=NREQ-1 searches from 0.
//   - Unknown/default opcode: passed to ALU unchanged; the X result is forwarded without check.
//   - rst asserted in any state: in-flight op is discarded, no rsp_valid is produced,
//     all registers return to reset values on the next edge.
//   - alu_op/alu_in* are held after RESP (not cleared) to avoid needless ALU toggling.
// CONFIGURATION
//   ALU_SCHED_PRIO0_EN defined: requester 0 has fixed priority. If req_valid[0]=1 in IDLE it
//     wins regardless of last_grant. last_grant is not updated by requester-0 grants.
//     Round-robin applies among 1..NREQ-1 only.
//   Not defined: pure round-robin over all NREQ as described above.
// TESTING
//   1. Reset, req0 ADD in0=8'h05 in1=8'h03 -> req_ready[0] same cycle, rsp_valid[0] 2 cycles
//      later, rsp_out=8'h08, rsp_zf=1.
//   2. req1 SUB in0=8'h03 in1=8'h05, rsp_ready held low 4 cycles -> rsp_out=8'h02 stable,
//      rsp_valid[1] held, req_ready all 0 throughout.
//   3. All 4 valid continuously -> grants in order 0,1,2,3,0 (no PRIO0_EN). With
//      ALU_SCHED_PRIO0_EN: order 0,0,0... while req0 stays valid.
//   4. req2 CMP in0=in1=8'h7F -> rsp_out=8'h01, rsp_zf=1. Then AND 8'hF0 & 8'h0F ->
//      rsp_out=8'h00, rsp_zf=0.
//   5. rst pulsed in EXEC -> no rsp_valid. Next req3 is accepted, but req0 wins if also valid
//      (last_grant reset).
//   6. req_valid[1] pulsed low/high while another op is in flight -> no spurious req_ready.
//      Granted only after return to IDLE.

Source files
------------

// File: rtl/alu_sched_if.sv
// Requester-side bus of the ALU scheduler: per-requester valid/ready request
// channels carrying op and operands, and per-requester valid/ready response
// channels sharing one registered result/zf pair.
interface alu_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_in0;
    logic [W*NREQ-1:0] req_in1;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_out;
    logic              rsp_zf;

    // Requester side
    modport master (
        output req_valid, req_op, req_in0, req_in1, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_zf
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_op, req_in0, req_in1, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_zf
    );
endinterface

// File: rtl/alu_sched.sv
// ALU scheduler: shares one combinational ALU among NREQ requesters using
// round-robin arbitration, one operation in flight at a time.
// Optional build macro ALU_SCHED_PRIO0_EN gives requester 0 fixed priority;
// round-robin then applies among requesters 1..NREQ-1 only.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | arbitrate; req_ready one-hot on the winner, accept latches op
//   EXEC  | ALU inputs stable from latched registers; result captured
//   RESP  | rsp_valid[id] high, result held until rsp_ready[id]
module alu_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    alu_sched_if.slave   bus,
    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_in0,
    output logic [W-1:0] alu_in1,
    input  logic [W-1:0] alu_out,
    input  logic         alu_zf
);
    localparam int GW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   id;
    logic [GW-1:0]   winner;
    logic            win_found;
    logic [GW-1:0]   idx;
    logic [NREQ-1:0] ready_c;
    logic [NREQ-1:0] rsp_valid_c;
    logic            accept;
    logic [W-1:0]    rsp_out_q;
    logic            rsp_zf_q;

    // Winner search: first valid requester after last_grant, wrapping modulo NREQ
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = GW'((int'(last_grant) + k) % NREQ);
            if (!win_found && bus.req_valid[idx]) begin
                winner    = idx;
                win_found = 1'b1;
            end
        end
`ifdef ALU_SCHED_PRIO0_EN
        if (bus.req_valid[0]) begin
            winner    = '0;
            win_found = 1'b1;
        end
`endif
    end

    // Grant and response strobes; grants are suppressed while reset is held so
    // a requester never sees a handshake that the scheduler will discard
    always_comb begin
        ready_c     = '0;
        rsp_valid_c = '0;
        if (!rst && state == IDLE && win_found) begin
            ready_c[winner] = 1'b1;
        end
        if (state == RESP) begin
            rsp_valid_c[id] = 1'b1;
        end
    end

    assign accept        = |(bus.req_valid & ready_c);
    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_zf    = rsp_zf_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready[id]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch on accept, result capture in EXEC; ALU inputs are held
    // afterwards so the ALU does not toggle between operations
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op     <= '0;
            alu_in0    <= '0;
            alu_in1    <= '0;
            id         <= '0;
            last_grant <= GW'(NREQ - 1);
            rsp_out_q  <= '0;
            rsp_zf_q   <= 1'b0;
        end else begin
            if (accept) begin
                alu_op  <= bus.req_op[int'(winner)*4 +: 4];
                alu_in0 <= bus.req_in0[int'(winner)*W +: W];
                alu_in1 <= bus.req_in1[int'(winner)*W +: W];
                id      <= winner;
`ifdef ALU_SCHED_PRIO0_EN
                if (winner != '0) begin
                    last_grant <= winner;
                end
`else
                last_grant <= winner;
`endif
            end
            if (state == EXEC) begin
                rsp_out_q <= alu_out;
                rsp_zf_q  <= alu_zf;
            end
        end
    end
endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: a behavioural ALU drives the DUT's ALU
// port; a scoreboard queue holds the expected result of each accepted
// operation and a negedge monitor checks grants, latency and results.
// Honours ALU_SCHED_PRIO0_EN the same way the design does.
module tb_alu_sched;
    localparam int NREQ = 4;
    localparam int W    = 8;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_CMP = 4'd5;

    typedef struct {
        int         id;
        logic [7:0] out;
        logic       zf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_sched_if #(.NREQ(NREQ), .W(W)) bus();
    logic [3:0]   alu_op;
    logic [W-1:0] alu_in0;
    logic [W-1:0] alu_in1;
    logic [W-1:0] alu_out;
    logic         alu_zf;

    alu_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .alu_op  (alu_op),
        .alu_in0 (alu_in0),
        .alu_in1 (alu_in1),
        .alu_out (alu_out),
        .alu_zf  (alu_zf)
    );

    int              n_checks = 0;
    int              n_fail   = 0;
    exp_t            sbq[$];
    int              dut_grants[$];
    logic [NREQ-1:0] acc_mask = '0;
    bit              busy     = 1'b0;
    int              age      = 0;
    int              cur_id   = 0;
    int              last     = NREQ - 1;

    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return b - a;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return (a == b) ? 8'h01 : 8'h00;
            4'd6:    return ~a;
            4'd7:    return b;
            default: return a ^ 8'hA5;
        endcase
    endfunction

    // Behavioural ALU attached to the DUT
    always_comb begin
        alu_out = alu_fn(alu_op, alu_in0, alu_in1);
        alu_zf  = (alu_out != 8'h00);
    end

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Fair pick: lowest valid index above the previous grant, else the lowest valid
    function automatic int pick(input logic [NREQ-1:0] v, input int lastg);
        int lo;
        lo = -1;
`ifdef ALU_SCHED_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                if (i > lastg) return i;
                if (lo < 0) lo = i;
            end
        end
        return lo;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and scoreboard: compares DUT outputs to the reference model, then advances it
    always @(negedge clk) begin : mon
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rv;
        int              w;
        exp_t            e;
        acc_mask = rst ? '0 : (bus.req_valid & bus.req_ready);
        for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i]) dut_grants.push_back(i);
        end
        exp_rv = (busy && age >= 2) ? onehot(cur_id) : '0;
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        if (exp_rv != '0 && sbq.size() > 0) begin
            check("rsp_out", 32'(bus.rsp_out), 32'(sbq[0].out));
            check("rsp_zf", 32'(bus.rsp_zf), 32'(sbq[0].zf));
        end
        if (rst) begin
            check("req_ready_in_reset", 32'(bus.req_ready), 32'(0));
            busy = 1'b0;
            age  = 0;
            last = NREQ - 1;
            sbq.delete();
        end else begin
            w       = pick(bus.req_valid, last);
            exp_rdy = (!busy && w >= 0) ? onehot(w) : '0;
            check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            if (busy) begin
                if (age >= 2 && bus.rsp_ready[cur_id]) begin
                    if (sbq.size() > 0) void'(sbq.pop_front());
                    busy = 1'b0;
                end else begin
                    age++;
                end
            end else if (w >= 0) begin
                e.id  = w;
                e.out = alu_fn(bus.req_op[4*w +: 4], bus.req_in0[8*w +: 8], bus.req_in1[8*w +: 8]);
                e.zf  = (e.out != 8'h00);
                sbq.push_back(e);
                busy   = 1'b1;
                age    = 1;
                cur_id = w;
`ifdef ALU_SCHED_PRIO0_EN
                if (w != 0) last = w;
`else
                last = w;
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req_op[4*i +: 4]  = op;
        bus.req_in0[8*i +: 8] = a;
        bus.req_in1[8*i +: 8] = b;
        bus.req_valid[i]      = 1'b1;
    endtask

    task automatic set_rand(input int i);
        set_req(i, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    endtask

    task automatic wait_acc(input int i, input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc_mask[i] && n < 40);
        check(name, 32'(acc_mask[i]), 32'(1));
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        step();
    endtask

    initial begin
        logic [NREQ-1:0] exp_order [5];
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_in0   = '0;
        bus.req_in1   = '0;
        bus.rsp_ready = '1;
        rst           = 1'b1;
        repeat (3) step();

        // Reset state
        bus.req_valid = '1;
        #1;
        check("reset_req_ready", 32'(bus.req_ready), 32'(0));
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("reset_rsp_out", 32'(bus.rsp_out), 32'(0));
        check("reset_rsp_zf", 32'(bus.rsp_zf), 32'(0));
        check("reset_alu_op", 32'(alu_op), 32'(0));
        check("reset_alu_in0", 32'(alu_in0), 32'(0));
        check("reset_alu_in1", 32'(alu_in1), 32'(0));
        bus.req_valid = '0;
        rst = 1'b0;
        step();

        // Requester 0 ADD 5+3 -> 8, zf=1
        set_req(0, OP_ADD, 8'h05, 8'h03);
        wait_acc(0, "t1_accept");
        wait_idle();

        // Requester 1 SUB with a stalled response; a competing request must wait
        bus.rsp_ready[1] = 1'b0;
        set_req(1, OP_SUB, 8'h03, 8'h05);
        wait_acc(1, "t2_accept");
        step();
        set_req(2, OP_ADD, 8'h10, 8'h20);
        repeat (4) step();
        bus.rsp_ready[1] = 1'b1;
        wait_acc(2, "t2_second_accept");
        wait_idle();

        // All requesters continuously valid from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        dut_grants.delete();
        for (int i = 0; i < NREQ; i++) set_rand(i);
        for (int n = 0; n < 60 && dut_grants.size() < 5; n++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (acc_mask[i]) set_rand(i);
            end
        end
        bus.req_valid = '0;
`ifdef ALU_SCHED_PRIO0_EN
        exp_order = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
`else
        exp_order = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
`endif
        check("t3_grant_count", 32'(dut_grants.size() >= 5), 32'(1));
        for (int k = 0; k < 5 && k < dut_grants.size(); k++) begin
            check("t3_grant_order", 32'(dut_grants[k]), 32'(exp_order[k]));
        end
        wait_idle();

        // CMP equal and AND to zero
        set_req(2, OP_CMP, 8'h7F, 8'h7F);
        wait_acc(2, "t4_cmp_accept");
        wait_idle();
        set_req(2, OP_AND, 8'hF0, 8'h0F);
        wait_acc(2, "t4_and_accept");
        wait_idle();

        // Reset during EXEC discards the operation and restores the pointer
        set_req(3, OP_ADD, 8'h01, 8'h02);
        wait_acc(3, "t5_accept");
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();
        set_req(0, OP_ADD, 8'h11, 8'h22);
        set_req(3, OP_SUB, 8'h01, 8'h09);
        wait_acc(0, "t5_req0_wins");
        wait_acc(3, "t5_req3_next");
        wait_idle();

        // Requester 1 toggling while another op is in flight
        set_req(0, OP_ADD, 8'h40, 8'h02);
        wait_acc(0, "t6_accept");
        set_req(1, OP_SUB, 8'h02, 8'h40);
        for (int n = 0; n < 5; n++) begin
            step();
            bus.req_valid[1] = ~bus.req_valid[1];
        end
        bus.req_valid[1] = 1'b1;
        wait_acc(1, "t6_req1_accept");
        wait_idle();

        // Randomised traffic with drops and response back-pressure
        for (int cyc = 0; cyc < 400; cyc++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (acc_mask[i]) begin
                    bus.req_valid[i] = 1'b0;
                end else if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_rand(i);
                end else if (bus.req_valid[i] && $urandom_range(0, 15) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
                bus.rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
        end
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        wait_idle();
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
